track_sequencer: RTL and testbench

- Two-track note recorder/player that sits directly upstream of the 7-segment display driver.
- Captures key presses (note, octave, accidental) into per-track memories and loops them back at a fixed step rate.
- Produces the note/octave/accident/track_playing/current_track signals consumed by the display and the tone generator.
- All outputs are registered.

---
 rtl/track_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_track_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/track_sequencer.sv
// track_sequencer: two-track note recorder/looper feeding the 7-segment display
// driver and tone generator. Each track stores up to DEPTH {note,octave,accident}
// entries. Playback steps on a shared free-running tick. All outputs are registered.
module track_sequencer #(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned STEP_TICKS = 25000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_valid,
    input  logic [2:0] key_note,
    input  logic [1:0] key_octave,
    input  logic       key_accident,
    input  logic       track_sel,
    input  logic       rec_toggle,
    input  logic [1:0] play_toggle,
    output logic [2:0] note,
    output logic [1:0] octave,
    output logic       accident,
    output logic       note_valid,
    output logic [1:0] track_playing,
    output logic       current_track,
    output logic       recording,
    output logic       full
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned CW = $clog2(STEP_TICKS);
    localparam logic [LW-1:0] LEN_FULL = LW'(DEPTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(STEP_TICKS - 1);

    typedef enum logic {
        S_IDLE,
        S_RECORD
    } state_t;

    state_t        state_q, state_d;
    logic [LW-1:0] len_q [2];
    logic [LW-1:0] len_d [2];
    logic [AW-1:0] ptr_q [2];
    logic [AW-1:0] ptr_d [2];
    logic [1:0]    play_d;
    logic          cur_d;
    logic          rec_start;

    logic [CW-1:0] cnt_q;
    logic          tick;

    logic [5:0]    mem [2][DEPTH];
    logic          we;
    logic [AW-1:0] waddr;
    logic [5:0]    wdata;

    logic [2:0]    note_d;
    logic [1:0]    octave_d;
    logic          accident_d;
    logic          valid_d;
    logic          full_d;

    assign tick = (cnt_q == CNT_LAST);

    // Free-running step counter shared by both tracks
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    // Next-state: record FSM, per-track playback and registered monitor values
    always_comb begin
        state_d    = state_q;
        cur_d      = current_track;
        len_d      = len_q;
        ptr_d      = ptr_q;
        play_d     = track_playing;
        we         = 1'b0;
        waddr      = len_q[current_track][AW-1:0];
        wdata      = {(key_note == 3'd7) ? 3'd0 : key_note, key_octave, key_accident};
        rec_start  = (state_q == S_IDLE) && rec_toggle;
        note_d     = note;
        octave_d   = octave;
        accident_d = accident;
        valid_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                cur_d = track_sel;
                if (rec_toggle) begin
                    state_d          = S_RECORD;
                    len_d[track_sel] = '0;
                end
            end
            S_RECORD: begin
                if (key_valid && (len_q[current_track] != LEN_FULL)) begin
                    we                   = 1'b1;
                    len_d[current_track] = len_q[current_track] + LW'(1);
                end
                if (rec_toggle) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Entering RECORD overrides any play toggle for the track being recorded;
        // the track currently recording ignores play toggles altogether.
        for (int unsigned i = 0; i < 2; i++) begin
            if (rec_start && (track_sel == i[0])) begin
                play_d[i[0]] = 1'b0;
            end else if (play_toggle[i[0]]
                         && !((state_q == S_RECORD) && (current_track == i[0]))
                         && (len_q[i[0]] != '0)) begin
                if (track_playing[i[0]]) begin
                    play_d[i[0]] = 1'b0;
                end else begin
                    play_d[i[0]] = 1'b1;
                    ptr_d[i[0]]  = '0;
                end
            end else if (tick && track_playing[i[0]]) begin
                if (({1'b0, ptr_q[i[0]]} + LW'(1)) == len_q[i[0]]) begin
                    ptr_d[i[0]] = '0;
                end else begin
                    ptr_d[i[0]] = ptr_q[i[0]] + AW'(1);
                end
            end
        end

        // Monitor values are derived from next-state so they appear one cycle
        // after the causing event.
        if (state_d == S_RECORD) begin
            if (we) begin
                {note_d, octave_d, accident_d} = wdata;
                valid_d = 1'b1;
            end else begin
                valid_d = (len_d[cur_d] != '0);
            end
        end else if (play_d[cur_d]) begin
            {note_d, octave_d, accident_d} = mem[cur_d][ptr_d[cur_d]];
            valid_d = 1'b1;
        end

        full_d = (len_d[cur_d] == LEN_FULL);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            len_q[0]      <= '0;
            len_q[1]      <= '0;
            ptr_q[0]      <= '0;
            ptr_q[1]      <= '0;
            track_playing <= '0;
            current_track <= 1'b0;
            recording     <= 1'b0;
            full          <= 1'b0;
            note          <= '0;
            octave        <= '0;
            accident      <= 1'b0;
            note_valid    <= 1'b0;
        end else begin
            state_q       <= state_d;
            len_q[0]      <= len_d[0];
            len_q[1]      <= len_d[1];
            ptr_q[0]      <= ptr_d[0];
            ptr_q[1]      <= ptr_d[1];
            track_playing <= play_d;
            current_track <= cur_d;
            recording     <= (state_d == S_RECORD);
            full          <= full_d;
            note          <= note_d;
            octave        <= octave_d;
            accident      <= accident_d;
            note_valid    <= valid_d;
        end
    end

    // Note memory write port (contents are not reset)
    always_ff @(posedge clk) begin
        if (we) begin
            mem[current_track][waddr] <= wdata;
        end
    end

endmodule

// File: tb/tb_track_sequencer.sv
// Testbench for track_sequencer: directed scenarios plus random stimulus, checked
// against a behavioural model through an expected-output scoreboard.
module tb_track_sequencer;

    localparam int DEPTH      = 4;
    localparam int STEP_TICKS = 4;

    logic       clk;
    logic       rst_n;
    logic       key_valid;
    logic [2:0] key_note;
    logic [1:0] key_octave;
    logic       key_accident;
    logic       track_sel;
    logic       rec_toggle;
    logic [1:0] play_toggle;
    logic [2:0] note;
    logic [1:0] octave;
    logic       accident;
    logic       note_valid;
    logic [1:0] track_playing;
    logic       current_track;
    logic       recording;
    logic       full;

    track_sequencer #(
        .DEPTH      (DEPTH),
        .STEP_TICKS (STEP_TICKS)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .key_valid     (key_valid),
        .key_note      (key_note),
        .key_octave    (key_octave),
        .key_accident  (key_accident),
        .track_sel     (track_sel),
        .rec_toggle    (rec_toggle),
        .play_toggle   (play_toggle),
        .note          (note),
        .octave        (octave),
        .accident      (accident),
        .note_valid    (note_valid),
        .track_playing (track_playing),
        .current_track (current_track),
        .recording     (recording),
        .full          (full)
    );

    typedef struct packed {
        logic [2:0] note;
        logic [1:0] octave;
        logic       accident;
        logic       note_valid;
        logic [1:0] playing;
        logic       cur;
        logic       rec;
        logic       full;
    } obs_t;

    int   total = 0;
    int   bad   = 0;
    obs_t sb [$];
    obs_t mon_exp, mon_got;

    // Behavioural model: track contents as appended lists, play position as index.
    bit [5:0] m_mem [2][DEPTH];
    int       m_len [2];
    int       m_pos [2];
    bit       m_play [2];
    bit       m_rec;
    bit       m_cur;
    int       m_cnt;
    obs_t     m_out;
    bit       sel;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t dut_obs();
        return {note, octave, accident, note_valid, track_playing, current_track, recording, full};
    endfunction

    task automatic report(input string name, input obs_t got, input obs_t want);
        $display("FAIL %s @%0t: got note=%0d oct=%0d acc=%0d nv=%0d play=%b cur=%0d rec=%0d full=%0d, want note=%0d oct=%0d acc=%0d nv=%0d play=%b cur=%0d rec=%0d full=%0d",
                 name, $time, got.note, got.octave, got.accident, got.note_valid, got.playing,
                 got.cur, got.rec, got.full, want.note, want.octave, want.accident,
                 want.note_valid, want.playing, want.cur, want.rec, want.full);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_len[i]  = 0;
            m_pos[i]  = 0;
            m_play[i] = 1'b0;
        end
        m_rec = 1'b0;
        m_cur = 1'b0;
        m_cnt = 0;
        m_out = '0;
    endtask

    task automatic model_step(input bit kv, input bit [2:0] kn, input bit [1:0] ko,
                              input bit ka, input bit ts, input bit rt, input bit [1:0] pt);
        bit       tick, start_rec, wrote, cur_next;
        bit [5:0] entry;
        int       old_len [2];
        tick      = (m_cnt == STEP_TICKS - 1);
        m_cnt     = tick ? 0 : m_cnt + 1;
        entry     = {(kn == 3'd7) ? 3'd0 : kn, ko, ka};
        old_len   = m_len;
        start_rec = !m_rec && rt;
        wrote     = 1'b0;
        cur_next  = m_rec ? m_cur : ts;
        if (m_rec && kv && m_len[m_cur] < DEPTH) begin
            m_mem[m_cur][m_len[m_cur]] = entry;
            m_len[m_cur]++;
            wrote = 1'b1;
        end
        if (start_rec) m_len[ts] = 0;
        for (int i = 0; i < 2; i++) begin
            if (start_rec && int'(ts) == i) begin
                m_play[i] = 1'b0;
            end else if (pt[i] && !(m_rec && int'(m_cur) == i) && old_len[i] > 0) begin
                if (m_play[i]) begin
                    m_play[i] = 1'b0;
                end else begin
                    m_play[i] = 1'b1;
                    m_pos[i]  = 0;
                end
            end else if (tick && m_play[i]) begin
                m_pos[i] = (m_pos[i] + 1) % old_len[i];
            end
        end
        m_rec = m_rec ? !rt : rt;
        m_cur = cur_next;
        if (m_rec) begin
            if (wrote) {m_out.note, m_out.octave, m_out.accident} = entry;
            m_out.note_valid = (m_len[m_cur] > 0);
        end else if (m_play[m_cur]) begin
            {m_out.note, m_out.octave, m_out.accident} = m_mem[m_cur][m_pos[m_cur]];
            m_out.note_valid = 1'b1;
        end else begin
            m_out.note_valid = 1'b0;
        end
        m_out.playing = {m_play[1], m_play[0]};
        m_out.cur     = m_cur;
        m_out.rec     = m_rec;
        m_out.full    = (m_len[m_cur] == DEPTH);
        sb.push_back(m_out);
    endtask

    // Drive one clock of stimulus and record the expected response
    task automatic cyc(input bit kv, input bit [2:0] kn, input bit [1:0] ko, input bit ka,
                       input bit rt, input bit [1:0] pt);
        @(negedge clk);
        rst_n        = 1'b1;
        key_valid    = kv;
        key_note     = kn;
        key_octave   = ko;
        key_accident = ka;
        track_sel    = sel;
        rec_toggle   = rt;
        play_toggle  = pt;
        model_step(kv, kn, ko, ka, sel, rt, pt);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 2'b00);
    endtask

    task automatic key(input bit [2:0] kn, input bit [1:0] ko, input bit ka);
        cyc(1'b1, kn, ko, ka, 1'b0, 2'b00);
    endtask

    task automatic check_reset(input string name);
        obs_t got;
        got = dut_obs();
        total++;
        if (got !== obs_t'('0)) begin
            bad++;
            report(name, got, '0);
        end
    endtask

    // Asynchronous reset in the middle of a cycle; released by the next cyc()
    task automatic do_reset(input string name);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset(name);
        model_reset();
        sb.delete();
        repeat (2) @(posedge clk);
    endtask

    // Monitor: compare DUT outputs with the scoreboard after each active edge
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            mon_exp = sb.pop_front();
            mon_got = dut_obs();
            total++;
            if (mon_got !== mon_exp) begin
                bad++;
                report("outputs", mon_got, mon_exp);
            end
        end
    end

    initial begin
        rst_n        = 1'b0;
        key_valid    = 1'b0;
        key_note     = '0;
        key_octave   = '0;
        key_accident = 1'b0;
        track_sel    = 1'b0;
        rec_toggle   = 1'b0;
        play_toggle  = '0;
        sel          = 1'b0;
        model_reset();
        #12;
        check_reset("reset_state");

        // play toggle on an empty track after reset is ignored
        cyc(1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 2'b01);
        idle(2);

        // record track 0: C1, E2#, G3
        sel = 1'b0;
        idle(1);
        cyc(1'b0, 3'd0, 2'd0, 1'b0, 1'b1, 2'b00);
        key(3'd0, 2'd1, 1'b0);
        key(3'd2, 2'd2, 1'b1);
        key(3'd4, 2'd3, 1'b0);
        idle(1);
        cyc(1'b0, 3'd0, 2'd0, 1'b0, 1'b1, 2'b00);
        idle(1);

        // record track 1 with overflow: D,E,F,G,A (A ignored), note 7 wraps test later
        sel = 1'b1;
        idle(1);
        cyc(1'b0, 3'd0, 2'd0, 1'b0, 1'b1, 2'b00);
        for (int n = 1; n <= 5; n++) key(3'(n), 2'd1, 1'b0);
        cyc(1'b0, 3'd0, 2'd0, 1'b0, 1'b1, 2'b00);

        // playback of track 0, then both, then monitor switch
        sel = 1'b0;
        idle(1);
        cyc(1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 2'b01);
        idle(13);
        cyc(1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 2'b10);
        idle(9);
        sel = 1'b1;
        idle(18);
        sel = 1'b0;
        idle(5);

        // collision: stop track 1, then rec + play 11 while track 0 plays
        cyc(1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 2'b10);
        idle(2);
        cyc(1'b0, 3'd0, 2'd0, 1'b0, 1'b1, 2'b11);
        idle(2);
        key(3'd7, 2'd2, 1'b1);
        cyc(1'b1, 3'd6, 2'd0, 1'b1, 1'b1, 2'b00);
        idle(2);

        // reset mid-playback, then play on the now-empty track is ignored
        cyc(1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 2'b01);
        idle(5);
        do_reset("reset_mid_play");
        cyc(1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 2'b01);
        idle(3);

        // randomized traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            bit       kv, rt;
            bit [1:0] pt;
            if ($urandom_range(0, 19) == 0) sel = ~sel;
            kv = ($urandom_range(0, 9) < 3);
            rt = ($urandom_range(0, 24) == 0);
            pt = {($urandom_range(0, 19) == 0), ($urandom_range(0, 19) == 0)};
            cyc(kv, 3'($urandom), 2'($urandom), 1'($urandom), rt, pt);
            if (n % 1000 == 999) do_reset("reset_random");
        end
        idle(3);

        @(posedge clk);
        #2;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
